// File: rtl/lc3b_types.sv
// Shared LC-3b type definitions: machine word and instruction-cache controller states.
package lc3b_types;

   typedef logic [15:0] lc3b_word;

   typedef enum logic [1:0] {
      CHECK  = 2'd0,
      FILL   = 2'd1,
      SETTLE = 2'd2
   } lc3b_icache_state_t;

   localparam int ICACHE_OFFSET_BITS = 4;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones; a synchronous clear takes priority over an increment.
module sat_counter #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             inc,
   output logic [WIDTH-1:0] count
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (inc && (count != {WIDTH{1'b1}})) begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/i_cache_control.sv
// Control FSM for the 2-way instruction cache: zero-wait hits, line fill on miss,
// and saturating hit/miss counters for performance measurement.
module i_cache_control
   import lc3b_types::*;
#(
   parameter int CTR_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 mem_read,
   input  lc3b_word             mem_address,
   output logic                 mem_resp,
   input  logic                 hit,
   input  logic                 lru_out,
   input  logic                 waydatamux_sel,
   output logic                 lru_write,
   output logic                 lru_data,
   output logic                 way0_write,
   output logic                 way1_write,
   output logic                 way0_valid_data,
   output logic                 way1_valid_data,
   output logic                 pmem_read,
   output lc3b_word             pmem_address,
   input  logic                 pmem_resp,
   input  logic                 ctr_clear,
   output logic [CTR_WIDTH-1:0] hit_count,
   output logic [CTR_WIDTH-1:0] miss_count
);

   localparam int LINE_W = 16 - ICACHE_OFFSET_BITS;

   lc3b_icache_state_t state;
   logic               victim;
   logic [LINE_W-1:0]  line_addr;
   logic               hit_evt;
   logic               miss_evt;
   logic               unused_offset;

   // Byte offset within the line never reaches memory; fills are line-aligned.
   assign unused_offset = ^mem_address[ICACHE_OFFSET_BITS-1:0];

   assign hit_evt  = (state == CHECK) && mem_read && hit;
   assign miss_evt = (state == CHECK) && mem_read && !hit;

   // Victim and line address are captured at miss time so datapath inputs
   // changing during the fill cannot redirect it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= CHECK;
         victim    <= 1'b0;
         line_addr <= '0;
      end else begin
         case (state)
            CHECK: begin
               if (miss_evt) begin
                  victim    <= lru_out;
                  line_addr <= mem_address[15:ICACHE_OFFSET_BITS];
                  state     <= FILL;
               end
            end
            FILL: begin
               if (pmem_resp) begin
                  state <= SETTLE;
               end
            end
            SETTLE: begin
               state <= CHECK;
            end
            default: begin
               state <= CHECK;
            end
         endcase
      end
   end

   always_comb begin
      mem_resp   = 1'b0;
      lru_write  = 1'b0;
      lru_data   = 1'b0;
      way0_write = 1'b0;
      way1_write = 1'b0;
      pmem_read  = 1'b0;
      case (state)
         CHECK: begin
            if (hit_evt) begin
               mem_resp  = 1'b1;
               lru_write = 1'b1;
               lru_data  = ~waydatamux_sel;
            end
         end
         FILL: begin
            pmem_read = 1'b1;
            if (pmem_resp) begin
               way0_write = ~victim;
               way1_write = victim;
            end
         end
         default: begin
         end
      endcase
   end

   assign pmem_address    = {line_addr, {ICACHE_OFFSET_BITS{1'b0}}};
   assign way0_valid_data = 1'b1;
   assign way1_valid_data = 1'b1;

   sat_counter #(.WIDTH(CTR_WIDTH)) u_hit_ctr (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (ctr_clear),
      .inc   (hit_evt),
      .count (hit_count)
   );

   sat_counter #(.WIDTH(CTR_WIDTH)) u_miss_ctr (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (ctr_clear),
      .inc   (miss_evt),
      .count (miss_count)
   );

endmodule

// File: tb/tb_i_cache_control.sv
// Self-checking bench for i_cache_control with a queue of expected line fills.
module tb_i_cache_control;

   localparam int CW  = 4;
   localparam int MAX = (1 << CW) - 1;

   logic          clk;
   logic          rst_n;
   logic          mem_read;
   logic [15:0]   mem_address;
   logic          mem_resp;
   logic          hit;
   logic          lru_out;
   logic          waydatamux_sel;
   logic          lru_write;
   logic          lru_data;
   logic          way0_write;
   logic          way1_write;
   logic          way0_valid_data;
   logic          way1_valid_data;
   logic          pmem_read;
   logic [15:0]   pmem_address;
   logic          pmem_resp;
   logic          ctr_clear;
   logic [CW-1:0] hit_count;
   logic [CW-1:0] miss_count;

   typedef struct {
      logic [15:0] addr;
      logic        way;
   } fill_t;

   fill_t exp_q[$];
   int    n_checks;
   int    n_fail;
   int    exp_hits;
   int    exp_misses;

   i_cache_control #(.CTR_WIDTH(CW)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .mem_read        (mem_read),
      .mem_address     (mem_address),
      .mem_resp        (mem_resp),
      .hit             (hit),
      .lru_out         (lru_out),
      .waydatamux_sel  (waydatamux_sel),
      .lru_write       (lru_write),
      .lru_data        (lru_data),
      .way0_write      (way0_write),
      .way1_write      (way1_write),
      .way0_valid_data (way0_valid_data),
      .way1_valid_data (way1_valid_data),
      .pmem_read       (pmem_read),
      .pmem_address    (pmem_address),
      .pmem_resp       (pmem_resp),
      .ctr_clear       (ctr_clear),
      .hit_count       (hit_count),
      .miss_count      (miss_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_checks++;
      if (obs !== exp_v) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
      end
   endtask

   function automatic int sat_inc(input int v);
      return (v >= MAX) ? MAX : v + 1;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_hit(input logic way);
      logic exp_lru;
      exp_lru        = !way;
      mem_read       = 1'b1;
      hit            = 1'b1;
      waydatamux_sel = way;
      #1;
      chk("hit_resp",      mem_resp, 1);
      chk("hit_lru_write", lru_write, 1);
      chk("hit_lru_data",  lru_data, exp_lru);
      chk("hit_no_way_wr", {way0_write, way1_write}, 0);
      exp_hits = sat_inc(exp_hits);
      step();
      mem_read = 1'b0;
      hit      = 1'b0;
      #1;
      chk("hit_count", hit_count, exp_hits);
   endtask

   task automatic do_miss(input logic [15:0] addr, input logic vic, input int lat,
                          input int drop_at, input bit toggle, input bit follow);
      fill_t e;
      int    k;
      mem_read    = 1'b1;
      hit         = 1'b0;
      mem_address = addr;
      lru_out     = vic;
      exp_q.push_back('{addr & 16'hFFF0, vic});
      #1;
      chk("miss_no_resp", mem_resp, 0);
      chk("miss_no_lru",  lru_write, 0);
      exp_misses = sat_inc(exp_misses);
      step();
      k = 0;
      while (!pmem_read && k < 4) begin
         step();
         k++;
      end
      chk("pmem_read_start", pmem_read, 1);
      e = exp_q.pop_front();
      chk("pmem_address", pmem_address, e.addr);
      chk("miss_count",   miss_count, exp_misses);
      for (int i = 0; i < lat; i++) begin
         if (toggle) lru_out = !vic;
         if (i == drop_at) mem_read = 1'b0;
         #1;
         chk("fill_hold",    pmem_read, 1);
         chk("fill_no_wr",   {way0_write, way1_write}, 0);
         chk("fill_no_resp", mem_resp, 0);
         step();
      end
      pmem_resp = 1'b1;
      #1;
      chk("fill_way0_wr",  way0_write, !e.way);
      chk("fill_way1_wr",  way1_write, e.way);
      chk("fill_no_lru",   lru_write, 0);
      chk("fill_resp_off", mem_resp, 0);
      step();
      pmem_resp = 1'b0;
      hit       = follow;
      #1;
      chk("settle_idle", {pmem_read, way0_write, way1_write, lru_write, mem_resp}, 0);
      step();
      if (follow) begin
         do_hit(e.way);
      end else begin
         #1;
         chk("abort_no_resp", mem_resp, 0);
         chk("abort_idle",    pmem_read, 0);
      end
   endtask

   initial begin
      fill_t e;
      n_checks       = 0;
      n_fail         = 0;
      exp_hits       = 0;
      exp_misses     = 0;
      rst_n          = 1'b0;
      mem_read       = 1'b0;
      mem_address    = 16'h0000;
      hit            = 1'b0;
      lru_out        = 1'b0;
      waydatamux_sel = 1'b0;
      pmem_resp      = 1'b0;
      ctr_clear      = 1'b0;
      #12;
      chk("rst_strobes", {mem_resp, lru_write, lru_data, way0_write, way1_write, pmem_read}, 0);
      chk("rst_valid",   {way0_valid_data, way1_valid_data}, 2'b11);
      chk("rst_paddr",   pmem_address, 0);
      chk("rst_hits",    hit_count, 0);
      chk("rst_misses",  miss_count, 0);
      rst_n = 1'b1;
      step();
      #1;
      chk("idle_no_resp", mem_resp, 0);

      // Cold miss, victim way0, response on the fifth fill cycle.
      do_miss(16'h3046, 1'b0, 4, -1, 1'b0, 1'b1);
      chk("cold_hits", hit_count, 1);
      chk("cold_misses", miss_count, 1);

      do_hit(1'b1);
      do_hit(1'b0);

      // Victim way1 with lru_out flipping during the fill.
      do_miss(16'h5A1C, 1'b1, 3, -1, 1'b1, 1'b1);

      // Request withdrawn two cycles into the fill.
      do_miss(16'h7720, 1'b0, 3, 1, 1'b0, 1'b0);

      // Stray memory response while idle.
      pmem_resp = 1'b1;
      #1;
      chk("stray_resp_wr", {way0_write, way1_write}, 0);
      step();
      pmem_resp = 1'b0;
      #1;
      chk("stray_resp_state", pmem_read, 0);

      // Asynchronous reset in the middle of a fill.
      mem_read    = 1'b1;
      hit         = 1'b0;
      mem_address = 16'h1234;
      exp_q.push_back('{16'h1230, 1'b0});
      step();
      e = exp_q.pop_front();
      chk("rf_pmem_read", pmem_read, 1);
      chk("rf_paddr",     pmem_address, e.addr);
      step();
      #2;
      rst_n = 1'b0;
      #1;
      chk("rf_pmem_drop", pmem_read, 0);
      chk("rf_no_wr",     {way0_write, way1_write}, 0);
      chk("rf_hits",      hit_count, 0);
      chk("rf_misses",    miss_count, 0);
      exp_hits   = 0;
      exp_misses = 0;
      mem_read   = 1'b0;
      step();
      rst_n = 1'b1;
      #1;
      chk("rf_paddr_clr", pmem_address, 0);
      do_hit(1'b0);

      // Saturation: 17 more hits on a 4-bit counter.
      for (int i = 0; i < 17; i++) do_hit(i[0]);
      chk("sat_hits", hit_count, MAX);

      // Clear wins over a coincident hit.
      mem_read  = 1'b1;
      hit       = 1'b1;
      ctr_clear = 1'b1;
      step();
      mem_read  = 1'b0;
      hit       = 1'b0;
      ctr_clear = 1'b0;
      exp_hits   = 0;
      exp_misses = 0;
      #1;
      chk("clr_hits",   hit_count, 0);
      chk("clr_misses", miss_count, 0);

      do_miss(16'hBEEF, 1'b1, 2, -1, 1'b0, 1'b1);
      chk("post_clr_misses", miss_count, 1);
      chk("post_clr_hits",   hit_count, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
